// File: rtl/bp_l15_pkg.sv
// Shared types, constants and size mapping for the BP memory-command to L1.5 request decoder.
package bp_l15_pkg;

    localparam int unsigned paddr_width_p       = 40;
    localparam int unsigned mem_payload_width_p = 16;
    localparam int unsigned cce_block_width_p   = 64;
    localparam int unsigned l15_data_width_lp   = 64;

    typedef enum logic [1:0] {
        e_lce_nc_req_1 = 2'b00,
        e_lce_nc_req_2 = 2'b01,
        e_lce_nc_req_4 = 2'b10,
        e_lce_nc_req_8 = 2'b11
    } bp_lce_cce_nc_req_size_e;

    typedef enum logic [1:0] {
        E_IDLE = 2'b00,
        E_REQ  = 2'b01,
        E_WAIT = 2'b10
    } l15_dec_state_e;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    localparam logic [2:0] MSG_DATA_SIZE_0B  = 3'b000;
    localparam logic [2:0] MSG_DATA_SIZE_1B  = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B  = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B  = 3'b011;
    localparam logic [2:0] MSG_DATA_SIZE_8B  = 3'b100;
    localparam logic [2:0] MSG_DATA_SIZE_16B = 3'b101;

    typedef struct packed {
        logic [mem_payload_width_p-1:0] payload;
        bp_lce_cce_nc_req_size_e        nc_size;
        logic                           non_cacheable;
        logic [paddr_width_p-1:0]       addr;
    } bp_cce_mem_cmd_s;

    typedef struct packed {
        logic [mem_payload_width_p-1:0] payload;
        bp_lce_cce_nc_req_size_e        nc_size;
        logic                           non_cacheable;
        logic [paddr_width_p-1:0]       addr;
        logic [cce_block_width_p-1:0]   data;
    } bp_cce_mem_data_cmd_s;

    // Cacheable requests always move a full 16B block.
    function automatic logic [2:0] l15_size_f(input logic nc, input bp_lce_cce_nc_req_size_e sz);
        logic [2:0] r;
        if (!nc) begin
            r = MSG_DATA_SIZE_16B;
        end else begin
            case (sz)
                e_lce_nc_req_1: r = MSG_DATA_SIZE_1B;
                e_lce_nc_req_2: r = MSG_DATA_SIZE_2B;
                e_lce_nc_req_4: r = MSG_DATA_SIZE_4B;
                default:        r = MSG_DATA_SIZE_8B;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_l15_cmd_decoder_if.sv
// BP command channels plus L1.5 request/response and encoder side-band, as one bundle.
interface bp_l15_cmd_decoder_if;
    import bp_l15_pkg::*;

    bp_cce_mem_cmd_s          mem_cmd_i;
    logic                     mem_cmd_v_i;
    logic                     mem_cmd_yumi_o;
    bp_cce_mem_data_cmd_s     mem_data_cmd_i;
    logic                     mem_data_cmd_v_i;
    logic                     mem_data_cmd_yumi_o;

    logic                     transducer_l15_val;
    logic [4:0]               transducer_l15_rqtype;
    logic [2:0]               transducer_l15_size;
    logic [paddr_width_p-1:0] transducer_l15_address;
    logic [63:0]              transducer_l15_data;
    logic                     transducer_l15_nc;
    logic                     l15_transducer_ack;
    logic                     l15_transducer_val;

    logic [mem_payload_width_p-1:0] mem_payload;
    bp_lce_cce_nc_req_size_e        nc_size;
    logic                           transducer_l15_req_ack;

    modport master (
        input  mem_cmd_i, mem_cmd_v_i, mem_data_cmd_i, mem_data_cmd_v_i,
        input  l15_transducer_ack, l15_transducer_val,
        output mem_cmd_yumi_o, mem_data_cmd_yumi_o,
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
        output transducer_l15_address, transducer_l15_data, transducer_l15_nc,
        output mem_payload, nc_size, transducer_l15_req_ack
    );

    modport slave (
        output mem_cmd_i, mem_cmd_v_i, mem_data_cmd_i, mem_data_cmd_v_i,
        output l15_transducer_ack, l15_transducer_val,
        input  mem_cmd_yumi_o, mem_data_cmd_yumi_o,
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
        input  transducer_l15_address, transducer_l15_data, transducer_l15_nc,
        input  mem_payload, nc_size, transducer_l15_req_ack
    );

endinterface

// File: rtl/bp_l15_store_replicate.sv
// Replicates the low store bytes across 64 bits; BP_L15_STORE_BSWAP_EN reverses byte order afterwards.
module bp_l15_store_replicate
    import bp_l15_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [2:0]  i_size,
    output logic [63:0] o_data_c
);

    logic [63:0] w_rep;

    always_comb begin
        case (i_size)
            MSG_DATA_SIZE_1B: w_rep = {8{i_data[7:0]}};
            MSG_DATA_SIZE_2B: w_rep = {4{i_data[15:0]}};
            MSG_DATA_SIZE_4B: w_rep = {2{i_data[31:0]}};
            default:          w_rep = i_data;
        endcase
    end

`ifdef BP_L15_STORE_BSWAP_EN
    assign o_data_c = {<<8{w_rep}};
`else
    assign o_data_c = w_rep;
`endif

endmodule

// File: rtl/bp_l15_cmd_decoder.sv
// Turns BP read/write memory commands into single-outstanding L1.5 requests.
// Optional BP_L15_STORE_BSWAP_EN byte-swaps store data (see bp_l15_store_replicate).
module bp_l15_cmd_decoder
    import bp_l15_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_l15_cmd_decoder_if.master bus
);

    l15_dec_state_e                 r_state;
    l15_dec_state_e                 w_state_nxt;
    logic [4:0]                     r_rqtype;
    logic [2:0]                     r_size;
    logic [paddr_width_p-1:0]       r_addr;
    logic [63:0]                    r_data;
    logic                           r_nc;
    logic [mem_payload_width_p-1:0] r_payload;
    bp_lce_cce_nc_req_size_e        r_nc_size;
    logic                           w_cap_wr;
    logic                           w_cap_rd;
    logic                           w_req_ack;
    logic [63:0]                    w_store_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= E_IDLE;
            r_rqtype  <= LOAD_RQ;
            r_size    <= MSG_DATA_SIZE_0B;
            r_addr    <= '0;
            r_data    <= '0;
            r_nc      <= 1'b0;
            r_payload <= '0;
            r_nc_size <= e_lce_nc_req_1;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap_wr) begin
                r_rqtype  <= STORE_RQ;
                r_size    <= l15_size_f(bus.mem_data_cmd_i.non_cacheable, bus.mem_data_cmd_i.nc_size);
                r_addr    <= bus.mem_data_cmd_i.addr;
                r_data    <= bus.mem_data_cmd_i.data;
                r_nc      <= bus.mem_data_cmd_i.non_cacheable;
                r_payload <= bus.mem_data_cmd_i.payload;
                r_nc_size <= bus.mem_data_cmd_i.nc_size;
            end else if (w_cap_rd) begin
                r_rqtype  <= LOAD_RQ;
                r_size    <= l15_size_f(bus.mem_cmd_i.non_cacheable, bus.mem_cmd_i.nc_size);
                r_addr    <= bus.mem_cmd_i.addr;
                r_data    <= '0;
                r_nc      <= bus.mem_cmd_i.non_cacheable;
                r_payload <= bus.mem_cmd_i.payload;
                r_nc_size <= bus.mem_cmd_i.nc_size;
            end
        end
    end

    // Writes win arbitration; nothing is consumed or acknowledged while reset is high.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_wr    = 1'b0;
        w_cap_rd    = 1'b0;
        w_req_ack   = 1'b0;
        if (!reset_i) begin
            case (r_state)
                E_IDLE: begin
                    if (bus.mem_data_cmd_v_i) begin
                        w_cap_wr    = 1'b1;
                        w_state_nxt = E_REQ;
                    end else if (bus.mem_cmd_v_i) begin
                        w_cap_rd    = 1'b1;
                        w_state_nxt = E_REQ;
                    end
                end
                E_REQ: begin
                    if (bus.l15_transducer_ack) begin
                        w_req_ack   = 1'b1;
                        w_state_nxt = E_WAIT;
                    end
                end
                E_WAIT: begin
                    if (bus.l15_transducer_val) w_state_nxt = E_IDLE;
                end
                default: w_state_nxt = E_IDLE;
            endcase
        end
    end

    bp_l15_store_replicate u_replicate (
        .i_data   (r_data),
        .i_size   (r_size),
        .o_data_c (w_store_data)
    );

    assign bus.mem_data_cmd_yumi_o    = w_cap_wr;
    assign bus.mem_cmd_yumi_o         = w_cap_rd;
    assign bus.transducer_l15_val     = (r_state == E_REQ);
    assign bus.transducer_l15_rqtype  = r_rqtype;
    assign bus.transducer_l15_size    = r_size;
    assign bus.transducer_l15_address = r_addr;
    assign bus.transducer_l15_data    = w_store_data;
    assign bus.transducer_l15_nc      = r_nc;
    assign bus.mem_payload            = r_payload;
    assign bus.nc_size                = r_nc_size;
    assign bus.transducer_l15_req_ack = w_req_ack;

    a_resp_only_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.l15_transducer_val |-> (r_state == E_WAIT));

endmodule

// File: tb/tb_bp_l15_cmd_decoder.sv
// Bench for bp_l15_cmd_decoder: vector table, hand sequences and randomized transactions vs. a byte-level model.
module tb_bp_l15_cmd_decoder;
    import bp_l15_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bp_l15_cmd_decoder_if bus ();

    bp_l15_cmd_decoder dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [39:0] addr;
        logic        nc;
        logic [1:0]  ncs;
        logic [15:0] pl;
        logic [63:0] d;
        int          ack_dly;
        int          rsp_dly;
        logic [4:0]  e_rq;
        logic [2:0]  e_sz;
        logic [63:0] e_d;
    } vec_t;

`ifdef BP_L15_STORE_BSWAP_EN
    localparam logic [63:0] EXP_4B = 64'h4433_2211_4433_2211;
    localparam logic [63:0] EXP_2B = 64'hEFBE_EFBE_EFBE_EFBE;
    localparam logic [63:0] EXP_CB = 64'h7766_5544_3322_1100;
`else
    localparam logic [63:0] EXP_4B = 64'h1122_3344_1122_3344;
    localparam logic [63:0] EXP_2B = 64'hBEEF_BEEF_BEEF_BEEF;
    localparam logic [63:0] EXP_CB = 64'h0011_2233_4455_6677;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: l15 size code is log2(bytes)+1 for uncached requests, 16B code for cached ones.
    function automatic logic [2:0] m_size(input logic nc, input logic [1:0] s);
        return nc ? (3'(s) + 3'd1) : 3'd5;
    endfunction

    // Model: byte i of the store word is command byte (i mod nbytes), optionally mirrored.
    function automatic logic [63:0] m_data(input logic nc, input logic [1:0] s, input logic [63:0] d);
        int nb;
        logic [63:0] r;
        nb = nc ? (1 << s) : 8;
        r  = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef BP_L15_STORE_BSWAP_EN
            r[8*(7-i) +: 8] = d[8*(i % nb) +: 8];
`else
            r[8*i +: 8] = d[8*(i % nb) +: 8];
`endif
        end
        return r;
    endfunction

    task automatic drive_cmd(input logic wr, input logic [39:0] addr, input logic nc,
                             input logic [1:0] ncs, input logic [15:0] pl, input logic [63:0] d);
        if (wr) begin
            bus.mem_data_cmd_i.addr          = addr;
            bus.mem_data_cmd_i.non_cacheable = nc;
            bus.mem_data_cmd_i.nc_size       = bp_lce_cce_nc_req_size_e'(ncs);
            bus.mem_data_cmd_i.payload       = pl;
            bus.mem_data_cmd_i.data          = d;
            bus.mem_data_cmd_v_i             = 1'b1;
        end else begin
            bus.mem_cmd_i.addr          = addr;
            bus.mem_cmd_i.non_cacheable = nc;
            bus.mem_cmd_i.nc_size       = bp_lce_cce_nc_req_size_e'(ncs);
            bus.mem_cmd_i.payload       = pl;
            bus.mem_cmd_v_i             = 1'b1;
        end
    endtask

    // One full transaction from IDLE back to IDLE; inputs change on negedge, outputs sampled 1ns later.
    task automatic do_txn(input vec_t v, input logic ack_noise);
        @(negedge clk);
        drive_cmd(v.wr, v.addr, v.nc, v.ncs, v.pl, v.d);
        #1;
        chk(v.wr ? "wr_yumi" : "rd_yumi", v.wr ? bus.mem_data_cmd_yumi_o : bus.mem_cmd_yumi_o, 64'd1);
        chk("val_in_idle", 64'(bus.transducer_l15_val), 64'd0);
        @(negedge clk);
        bus.mem_cmd_v_i      = 1'b0;
        bus.mem_data_cmd_v_i = 1'b0;
        for (int k = 0; k < v.ack_dly; k++) begin
            #1;
            chk("val_wait_ack", 64'(bus.transducer_l15_val), 64'd1);
            chk("req_ack_early", 64'(bus.transducer_l15_req_ack), 64'd0);
            @(negedge clk);
        end
        bus.l15_transducer_ack = 1'b1;
        #1;
        chk("val_at_ack", 64'(bus.transducer_l15_val), 64'd1);
        chk("req_ack", 64'(bus.transducer_l15_req_ack), 64'd1);
        chk("rqtype", 64'(bus.transducer_l15_rqtype), 64'(v.e_rq));
        chk("size", 64'(bus.transducer_l15_size), 64'(v.e_sz));
        chk("addr", 64'(bus.transducer_l15_address), 64'(v.addr));
        chk("nc", 64'(bus.transducer_l15_nc), 64'(v.nc));
        chk("payload", 64'(bus.mem_payload), 64'(v.pl));
        chk("nc_size", 64'(bus.nc_size), 64'(v.ncs));
        if (v.wr) chk("store_data", bus.transducer_l15_data, v.e_d);
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        for (int k = 0; k < v.rsp_dly; k++) begin
            bus.l15_transducer_ack = ack_noise ? 1'($urandom_range(1)) : 1'b0;
            #1;
            chk("val_in_wait", 64'(bus.transducer_l15_val), 64'd0);
            chk("req_ack_pulse", 64'(bus.transducer_l15_req_ack), 64'd0);
            @(negedge clk);
        end
        bus.l15_transducer_ack = 1'b0;
        bus.l15_transducer_val = 1'b1;
        #1;
        chk("val_at_rsp", 64'(bus.transducer_l15_val), 64'd0);
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
    endtask

    vec_t vt[6];

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.mem_cmd_i          = '0;
        bus.mem_data_cmd_i     = '0;
        bus.mem_cmd_v_i        = 1'b0;
        bus.mem_data_cmd_v_i   = 1'b0;
        bus.l15_transducer_ack = 1'b0;
        bus.l15_transducer_val = 1'b0;

        vt[0] = '{1'b0, 40'h00_8000_1000, 1'b1, 2'd3, 16'h1234, 64'h0, 2, 1, 5'd0, 3'b100, 64'h0};
        vt[1] = '{1'b1, 40'h00_0000_2001, 1'b1, 2'd0, 16'h00A5, 64'h0123_4567_89AB_CDA5, 0, 0, 5'd1, 3'b001, 64'hA5A5_A5A5_A5A5_A5A5};
        vt[2] = '{1'b1, 40'h00_0000_3004, 1'b1, 2'd2, 16'h0042, 64'hDEAD_BEEF_1122_3344, 1, 2, 5'd1, 3'b011, EXP_4B};
        vt[3] = '{1'b1, 40'h00_0000_4002, 1'b1, 2'd1, 16'h0777, 64'h5555_6666_7777_BEEF, 3, 0, 5'd1, 3'b010, EXP_2B};
        vt[4] = '{1'b1, 40'h00_0000_5040, 1'b0, 2'd3, 16'hFFFF, 64'h0011_2233_4455_6677, 0, 3, 5'd1, 3'b101, EXP_CB};
        vt[5] = '{1'b0, 40'h12_3456_7840, 1'b0, 2'd0, 16'h8001, 64'h0, 1, 1, 5'd0, 3'b101, 64'h0};

        // Reset: all outputs zero, a valid read is not consumed while reset is high.
        @(negedge clk);
        bus.mem_cmd_v_i        = 1'b1;
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd0);
        chk("rst_wr_yumi", 64'(bus.mem_data_cmd_yumi_o), 64'd0);
        chk("rst_val", 64'(bus.transducer_l15_val), 64'd0);
        chk("rst_req_ack", 64'(bus.transducer_l15_req_ack), 64'd0);
        chk("rst_addr", 64'(bus.transducer_l15_address), 64'd0);
        chk("rst_data", bus.transducer_l15_data, 64'd0);
        chk("rst_size", 64'(bus.transducer_l15_size), 64'd0);
        chk("rst_rqtype", 64'(bus.transducer_l15_rqtype), 64'd0);
        chk("rst_nc", 64'(bus.transducer_l15_nc), 64'd0);
        chk("rst_payload", 64'(bus.mem_payload), 64'd0);
        chk("rst_nc_size", 64'(bus.nc_size), 64'd0);
        @(negedge clk);
        reset                  = 1'b0;
        bus.mem_cmd_v_i        = 1'b0;
        #1;
        chk("idle_ack_ignored", 64'(bus.transducer_l15_req_ack), 64'd0);
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;

        for (int i = 0; i < 6; i++) do_txn(vt[i], 1'b0);

        // Both valid: write first, read held off until the cycle after the write's response.
        @(negedge clk);
        drive_cmd(1'b1, 40'h00_0000_6000, 1'b1, 2'd2, 16'h0101, 64'h0000_0000_1122_3344);
        drive_cmd(1'b0, 40'h00_0000_7000, 1'b1, 2'd3, 16'h0202, 64'h0);
        #1;
        chk("both_wr_yumi", 64'(bus.mem_data_cmd_yumi_o), 64'd1);
        chk("both_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd0);
        @(negedge clk);
        bus.mem_data_cmd_v_i = 1'b0;
        #1;
        chk("both_req_rq", 64'(bus.transducer_l15_rqtype), 64'(STORE_RQ));
        chk("both_req_data", bus.transducer_l15_data, EXP_4B);
        chk("both_req_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd0);
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        #1;
        chk("wait_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd0);
        @(negedge clk);
        bus.l15_transducer_val = 1'b1;
        #1;
        chk("rsp_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd0);
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        chk("post_rsp_rd_yumi", 64'(bus.mem_cmd_yumi_o), 64'd1);
        @(negedge clk);
        bus.mem_cmd_v_i = 1'b0;
        #1;
        chk("read2_val", 64'(bus.transducer_l15_val), 64'd1);
        chk("read2_rq", 64'(bus.transducer_l15_rqtype), 64'(LOAD_RQ));
        chk("read2_addr", 64'(bus.transducer_l15_address), 64'h7000);
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        bus.l15_transducer_val = 1'b1;
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;

        // Reset during REQ drops the request with no req_ack.
        @(negedge clk);
        drive_cmd(1'b0, 40'h00_0000_9000, 1'b1, 2'd3, 16'h0303, 64'h0);
        #1;
        chk("prerst_yumi", 64'(bus.mem_cmd_yumi_o), 64'd1);
        @(negedge clk);
        bus.mem_cmd_v_i        = 1'b0;
        reset                  = 1'b1;
        bus.l15_transducer_ack = 1'b1;
        #1;
        chk("rst_req_no_ack", 64'(bus.transducer_l15_req_ack), 64'd0);
        @(negedge clk);
        reset                  = 1'b0;
        bus.l15_transducer_ack = 1'b0;
        #1;
        chk("postrst_val", 64'(bus.transducer_l15_val), 64'd0);
        chk("postrst_addr", 64'(bus.transducer_l15_address), 64'd0);
        v = '{1'b0, 40'h00_0000_A000, 1'b1, 2'd3, 16'h0404, 64'h0, 0, 0, 5'd0, 3'b100, 64'h0};
        do_txn(v, 1'b0);

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            v.wr      = 1'($urandom_range(1));
            v.addr    = {8'($urandom), 32'($urandom)};
            v.nc      = 1'($urandom_range(1));
            v.ncs     = 2'($urandom_range(3));
            v.pl      = 16'($urandom);
            v.d       = {32'($urandom), 32'($urandom)};
            v.ack_dly = int'($urandom_range(3));
            v.rsp_dly = int'($urandom_range(3));
            v.e_rq    = v.wr ? 5'd1 : 5'd0;
            v.e_sz    = m_size(v.nc, v.ncs);
            v.e_d     = m_data(v.nc, v.ncs, v.d);
            do_txn(v, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
